spi_regfile_periph: RTL

SPI_REGFILE_PERIPH -- requirements
Module: spi_regfile_periph

---
 rtl/spi_regfile_pkg.sv | 19 +
 rtl/spi_pad_sync.sv | 33 +++
 rtl/spi_regfile_periph.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register-file peripheral: transaction
// states, command-byte layout helper and synchroniser depth.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_state_t;

    // Number of flops between a pad and the logic that uses it
    localparam int SYNC_STAGES = 2;

    // The read/write flag is the MSB of the command byte
    function automatic int cmd_read_bit(input int byte_w);
        return byte_w - 1;
    endfunction

endpackage

// File: rtl/spi_pad_sync.sv
// Pad synchroniser: brings an asynchronous pad into the sys_clk domain and
// flags its rising and falling edges for one cycle each.
module spi_pad_sync #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);
    import spi_regfile_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pad through the synchroniser and remember the previous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 slave exposing a bank of host-writable registers followed by a
// bank of read-only status registers. The first byte of each CSN frame is a
// command (MSB = read flag, low bits = start address); every following byte
// accesses the current address, which then post-increments.
module spi_regfile_periph #(
    parameter int BYTE_W = 8,
    parameter int NUM_RW = 4,
    parameter int NUM_RO = 4,
    parameter int ADDR_W = BYTE_W - 1
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     CSN_PAD,
    input  logic                     SCK_PAD,
    input  logic                     MOSI_PAD,
    output logic                     MISO_PAD,
    output logic [NUM_RW*BYTE_W-1:0] rw_regs,
    output logic [NUM_RW-1:0]        wr_strobe,
    input  logic [NUM_RO*BYTE_W-1:0] ro_regs,
    output logic                     busy
);
    import spi_regfile_pkg::*;

    localparam int TOTAL    = NUM_RW + NUM_RO;
    localparam int READ_BIT = cmd_read_bit(BYTE_W);
    localparam int CNT_W    = $clog2(BYTE_W + 1);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    logic csn_level, csn_rise, csn_fall;
    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_pad_sync #(.IDLE_LEVEL(1'b1)) u_csn_sync (
        .clk(sys_clk), .rst_n(rst_n), .pad(CSN_PAD),
        .level(csn_level), .rise(csn_rise), .fall(csn_fall)
    );

    spi_pad_sync #(.IDLE_LEVEL(1'b0)) u_sck_sync (
        .clk(sys_clk), .rst_n(rst_n), .pad(SCK_PAD),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    spi_pad_sync #(.IDLE_LEVEL(1'b0)) u_mosi_sync (
        .clk(sys_clk), .rst_n(rst_n), .pad(MOSI_PAD),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_state_t               state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic [BYTE_W-1:0]        shift_in_q;
    logic [BYTE_W-1:0]        shift_out_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     is_read_q;
    logic [NUM_RW*BYTE_W-1:0] rw_q;
    logic [NUM_RW-1:0]        strobe_q;
    logic [SETTLE_W-1:0]      settle_q;
    logic                     armed_q;

    logic [BYTE_W-1:0] rx_byte;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] addr_inc;
    logic              byte_done;

    // Register or status value seen by the host at address a; holes read 0
    function automatic logic [BYTE_W-1:0] read_word(
        input logic [ADDR_W-1:0]        a,
        input logic [NUM_RW*BYTE_W-1:0] rw,
        input logic [NUM_RO*BYTE_W-1:0] ro
    );
        logic [BYTE_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_RW; k++)
            if (int'(a) == k) v = rw[k*BYTE_W +: BYTE_W];
        for (int k = 0; k < NUM_RO; k++)
            if (int'(a) == NUM_RW + k) v = ro[k*BYTE_W +: BYTE_W];
        return v;
    endfunction

    // Post-increment that wraps at the end of the mapped space
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (int'(a) == TOTAL - 1) return '0;
        return a + ADDR_W'(1);
    endfunction

    assign rx_byte   = {shift_in_q[BYTE_W-2:0], mosi_level};
    assign cmd_addr  = rx_byte[ADDR_W-1:0];
    assign addr_inc  = next_addr(addr_q);
    assign byte_done = sck_rise && !csn_level && (bit_cnt_q == LAST_BIT);

    // After reset the synchronisers start at idle levels, so a CSN that is
    // already low would look like a fresh falling edge; only arm once CSN has
    // been seen high after the synchronisers have flushed.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else if (settle_q != SETTLE_W'(SYNC_STAGES)) begin
            settle_q <= settle_q + SETTLE_W'(1);
        end else if (csn_level) begin
            armed_q  <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: CSN high always wins and returns the frame to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (csn_fall && armed_q) state_d = ST_CMD;
            ST_CMD:  if (byte_done) state_d = ST_DATA;
            ST_DATA: state_d = ST_DATA;
            default: state_d = ST_IDLE;
        endcase
        if (csn_level) state_d = ST_IDLE;
    end

    // Bit shifting, command decode, register writes and read-data loading.
    // Read data is loaded on the last rise of the preceding byte; the fall
    // that immediately follows (bit counter back at 0) must not shift it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            addr_q      <= '0;
            is_read_q   <= 1'b0;
            rw_q        <= '0;
            strobe_q    <= '0;
        end else begin
            strobe_q <= '0;
            if (state_q == ST_IDLE || csn_level) begin
                bit_cnt_q <= '0;
            end else if (sck_rise) begin
                shift_in_q <= rx_byte;
                if (byte_done) begin
                    bit_cnt_q <= '0;
                    if (state_q == ST_CMD) begin
                        is_read_q   <= rx_byte[READ_BIT];
                        addr_q      <= cmd_addr;
                        shift_out_q <= read_word(cmd_addr, rw_q, ro_regs);
                    end else begin
                        if (!is_read_q) begin
                            for (int k = 0; k < NUM_RW; k++) begin
                                if (int'(addr_q) == k) begin
                                    rw_q[k*BYTE_W +: BYTE_W] <= rx_byte;
                                    strobe_q[k]              <= 1'b1;
                                end
                            end
                        end
                        addr_q      <= addr_inc;
                        shift_out_q <= read_word(addr_inc, rw_q, ro_regs);
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
            end else if (sck_fall && bit_cnt_q != '0) begin
                shift_out_q <= {shift_out_q[BYTE_W-2:0], 1'b0};
            end
        end
    end

    assign MISO_PAD  = (state_q == ST_DATA && is_read_q) ? shift_out_q[BYTE_W-1] : 1'b0;
    assign rw_regs   = rw_q;
    assign wr_strobe = strobe_q;
    assign busy      = ~csn_level;

    logic unused_ok;
    assign unused_ok = &{1'b0, sck_level, mosi_rise, mosi_fall, csn_rise,
                         shift_in_q[BYTE_W-1]};

endmodule
